sram_phy_ctrl: RTL and testbench

SRAM_PHY_CTRL -- requirements
Module: sram_phy_ctrl

---
 rtl/sram_pkg.sv | 30 +++
 rtl/sram_phy_ctrl_if.sv | 33 +++
 rtl/sram_lane_ctrl.sv | 81 ++++++++
 rtl/sram_phy_ctrl.sv | 153 +++++++++++++++
 tb/tb_sram_phy_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the three-chip asynchronous SRAM PHY controller:
// the access FSM encoding, the chip count and data width, the default
// strobe timings and a helper that converts a cycle count into the value
// loaded into the shared phase counter.
// -----------------------------------------------------------------------------
package sram_pkg;

  localparam int unsigned NUM_CHIPS           = 3;
  localparam int unsigned CHIP_DW             = 16;
  localparam int unsigned BUS_DW              = NUM_CHIPS * CHIP_DW;
  localparam int unsigned RD_CYCLES_DEF       = 2;
  localparam int unsigned WR_PULSE_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } state_e;

  // The phase counter counts down to zero, so a phase lasting N cycles
  // starts from N-1.
  function automatic logic [3:0] phase_load(input int unsigned cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_phy_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_phy_ctrl_if
// Request/response bus between the line wrapper and the SRAM PHY controller.
//   wb_stb  : request strobe
//   wb_addr : byte address (bits [21:2] select the SRAM word)
//   wb_we   : byte write mask, all-zero selects a read
//   wb_din  : write data, 16 bits per chip
//   wb_dout : data of the most recently completed read
//   wb_nak  : busy, high while an access is in progress
// Modports: master (line wrapper side), slave (controller side).
// -----------------------------------------------------------------------------
interface sram_phy_ctrl_if
  import sram_pkg::*;
();

  logic              wb_stb;
  logic [31:0]       wb_addr;
  logic [5:0]        wb_we;
  logic [BUS_DW-1:0] wb_din;
  logic [BUS_DW-1:0] wb_dout;
  logic              wb_nak;

  modport master (
    output wb_stb, wb_addr, wb_we, wb_din,
    input  wb_dout, wb_nak
  );

  modport slave (
    input  wb_stb, wb_addr, wb_we, wb_din,
    output wb_dout, wb_nak
  );

endinterface

// File: rtl/sram_lane_ctrl.sv
// -----------------------------------------------------------------------------
// sram_lane_ctrl
// Per-chip strobe generator. From the next FSM state and the chip's next
// 2-bit byte mask it registers the chip's active-low strobes and the pad
// output enable, so every pad-side signal comes straight from a flop.
//   clk, rst : clock, asynchronous active-high reset
//   state_d  : FSM state for the coming cycle
//   mask_d   : {high byte, low byte} write mask for the coming cycle
//   ce_n, we_n, ub_n, lb_n, dq_oe : registered chip controls
// -----------------------------------------------------------------------------
module sram_lane_ctrl
  import sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  state_e     state_d,
  input  logic [1:0] mask_d,
  output logic       ce_n,
  output logic       we_n,
  output logic       ub_n,
  output logic       lb_n,
  output logic       dq_oe
);

  logic ce_n_d, we_n_d, ub_n_d, lb_n_d, dq_oe_d;
  logic ce_n_q, we_n_q, ub_n_q, lb_n_q, dq_oe_q;
  logic sel;

  // A chip with no mask bit set sits out the whole write.
  assign sel = |mask_d;

  always_comb begin
    ce_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    case (state_d)
      RD: begin
        // Reads always fetch both bytes of every chip; pads stay released.
        ce_n_d = 1'b0;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
      end
      WR_SETUP, WR_PULSE, WR_HOLD: begin
        ce_n_d  = ~sel;
        ub_n_d  = ~mask_d[1];
        lb_n_d  = ~mask_d[0];
        dq_oe_d = sel;
        if (state_d == WR_PULSE) begin
          we_n_d = ~sel;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      ce_n_q  <= ce_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  assign ce_n  = ce_n_q;
  assign we_n  = we_n_q;
  assign ub_n  = ub_n_q;
  assign lb_n  = lb_n_q;
  assign dq_oe = dq_oe_q;

endmodule

// File: rtl/sram_phy_ctrl.sv
// -----------------------------------------------------------------------------
// sram_phy_ctrl
// Controller for three 16-bit asynchronous SRAM chips sharing one address
// bus. Accepts single-word reads and masked writes from the line wrapper and
// sequences the chip strobes: a read holds oe_n low for RD_CYCLES cycles; a
// write runs setup (1), we_n pulse (WR_PULSE_CYCLES) and hold (1) cycles.
//   clk, rst     : clock, asynchronous active-high reset
//   wb           : request bus (slave side)
//   sram_ce_n/oe_n/we_n/ub_n/lb_n : per-chip active-low strobes
//   sram_addr    : shared word address
//   sram_dq_out  : write data to the pads, sram_dq_in : pad read data
//   sram_dq_oe   : per-chip pad output enable (tristate lives above)
// -----------------------------------------------------------------------------
module sram_phy_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned RD_CYCLES       = RD_CYCLES_DEF,
  parameter int unsigned WR_PULSE_CYCLES = WR_PULSE_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_phy_ctrl_if.slave       wb,
  output logic [NUM_CHIPS-1:0] sram_ce_n,
  output logic [NUM_CHIPS-1:0] sram_oe_n,
  output logic [NUM_CHIPS-1:0] sram_we_n,
  output logic [NUM_CHIPS-1:0] sram_ub_n,
  output logic [NUM_CHIPS-1:0] sram_lb_n,
  output logic [19:0]          sram_addr,
  output logic [BUS_DW-1:0]    sram_dq_out,
  input  logic [BUS_DW-1:0]    sram_dq_in,
  output logic [NUM_CHIPS-1:0] sram_dq_oe
);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [19:0]           addr_q, addr_d;
  logic [BUS_DW-1:0]     dq_out_q, dq_out_d;
  logic [BUS_DW-1:0]     dout_q, dout_d;
  logic [5:0]            mask_q, mask_d;
  logic                  nak_q, nak_d;
  logic [NUM_CHIPS-1:0]  oe_n_q, oe_n_d;
  logic                  accept;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{wb.wb_addr[31:22], wb.wb_addr[1:0]};

  assign accept = wb.wb_stb && !nak_q && (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    dout_d   = dout_q;
    mask_d   = mask_q;
    nak_d    = nak_q;
    oe_n_d   = oe_n_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Address, data and mask change only here, so they are stable
          // across the whole strobe window that follows.
          addr_d   = wb.wb_addr[21:2];
          mask_d   = wb.wb_we;
          dq_out_d = wb.wb_din;
          nak_d    = 1'b1;
          if (wb.wb_we == 6'd0) begin
            state_d = RD;
            cnt_d   = phase_load(RD_CYCLES);
            oe_n_d  = '0;
          end else begin
            state_d = WR_SETUP;
          end
        end
      end
      RD: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          dout_d  = sram_dq_in;
          nak_d   = 1'b0;
          oe_n_d  = '1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = phase_load(WR_PULSE_CYCLES);
      end
      WR_PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_HOLD: begin
        state_d = IDLE;
        nak_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        nak_d   = 1'b0;
        oe_n_d  = '1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      dout_q   <= '0;
      mask_q   <= '0;
      nak_q    <= 1'b0;
      oe_n_q   <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      dout_q   <= dout_d;
      mask_q   <= mask_d;
      nak_q    <= nak_d;
      oe_n_q   <= oe_n_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CHIPS; gi++) begin : g_lane
      sram_lane_ctrl u_lane (
        .clk    (clk),
        .rst    (rst),
        .state_d(state_d),
        .mask_d (mask_d[2*gi+1 -: 2]),
        .ce_n   (sram_ce_n[gi]),
        .we_n   (sram_we_n[gi]),
        .ub_n   (sram_ub_n[gi]),
        .lb_n   (sram_lb_n[gi]),
        .dq_oe  (sram_dq_oe[gi])
      );
    end
  endgenerate

  assign sram_oe_n   = oe_n_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign wb.wb_dout  = dout_q;
  assign wb.wb_nak   = nak_q;

endmodule

// File: tb/tb_sram_phy_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_phy_ctrl
// Directed bench: a table of single accesses with hand-computed pad values,
// then a 16-word read burst against a model SRAM, then reset mid-write.
// -----------------------------------------------------------------------------
module tb_sram_phy_ctrl;
  import sram_pkg::*;

  localparam int RD = 2;
  localparam int WP = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe;
  logic [19:0]  sram_addr;
  logic [47:0]  sram_dq_out, sram_dq_in, dq_drv;
  logic         model_en;

  int n_tests = 0;
  int n_fail  = 0;
  int overlap_errs = 0;

  sram_phy_ctrl_if wb_bus ();

  sram_phy_ctrl #(.RD_CYCLES(RD), .WR_PULSE_CYCLES(WP)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (wb_bus),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe)
  );

  always #5 clk = ~clk;

  // Model SRAM for the burst: word at byte address A reads back A*3.
  assign sram_dq_in = model_en ? ({26'd0, sram_addr, 2'b00} * 48'd3) : dq_drv;

  always @(negedge clk) begin
    if (!rst && ((sram_dq_oe & ~sram_oe_n) != 3'b000)) overlap_errs++;
  end

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [5:0]  we;
    logic [47:0] din;
    logic [47:0] dq_in;
    logic [19:0] exp_addr;
    logic [2:0]  exp_ce;
    logic [2:0]  exp_dq_oe;
    logic [2:0]  exp_ub;
    logic [2:0]  exp_lb;
    logic [47:0] exp_dout;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int nak_cyc, oe_cyc, we_cyc, win_err, guard;
    nak_cyc = 0; oe_cyc = 0; we_cyc = 0; win_err = 0; guard = 0;
    wb_bus.wb_stb  = 1'b1;
    wb_bus.wb_addr = v.addr;
    wb_bus.wb_we   = v.we;
    wb_bus.wb_din  = v.din;
    dq_drv         = v.dq_in;
    tick();
    // Scramble the request inputs: the access must use the latched copy.
    wb_bus.wb_stb  = 1'b0;
    wb_bus.wb_addr = ~v.addr;
    wb_bus.wb_we   = v.is_wr ? 6'h00 : 6'h3f;
    wb_bus.wb_din  = ~v.din;
    chk($sformatf("v%0d_accept_nak", idx), 64'(wb_bus.wb_nak), 64'd1);
    if (v.is_wr) chk($sformatf("v%0d_setup_we_n", idx), 64'(sram_we_n), 64'h7);
    while (wb_bus.wb_nak && guard < 50) begin
      guard++;
      nak_cyc++;
      if (sram_oe_n != 3'b111) begin
        oe_cyc++;
        if (sram_oe_n != 3'b000) win_err++;
      end
      if (sram_we_n != 3'b111) begin
        we_cyc++;
        if (sram_we_n != ~v.exp_dq_oe) win_err++;
      end
      if (sram_ce_n != v.exp_ce || sram_addr != v.exp_addr || sram_ub_n != v.exp_ub ||
          sram_lb_n != v.exp_lb || sram_dq_oe != v.exp_dq_oe) win_err++;
      if (v.is_wr && sram_dq_out != v.din) win_err++;
      tick();
    end
    chk($sformatf("v%0d_busy_cycles", idx), 64'(nak_cyc), v.is_wr ? 64'(WP + 2) : 64'(RD));
    chk($sformatf("v%0d_oe_cycles", idx), 64'(oe_cyc), v.is_wr ? 64'd0 : 64'(RD));
    chk($sformatf("v%0d_we_cycles", idx), 64'(we_cyc), v.is_wr ? 64'(WP) : 64'd0);
    chk($sformatf("v%0d_window_errs", idx), 64'(win_err), 64'd0);
    chk($sformatf("v%0d_dout", idx), 64'(wb_bus.wb_dout), 64'(v.exp_dout));
    chk($sformatf("v%0d_idle_strobes", idx),
        64'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}), 64'h3fff8);
    $display("[TB] vec %0d %s addr=0x%08h we=%06b busy=%0d dout=0x%012h",
             idx, v.is_wr ? "WR" : "RD", v.addr, v.we, nak_cyc, wb_bus.wb_dout);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] got[16];
    int k_acc, k_done, cyc, last_acc, per_err, we_after;
    logic prev_nak;

    //            wr addr           we         din                dq_in              addr      ce      dq_oe   ub      lb      dout
    vecs[0] = '{1'b0, 32'h0000_0040, 6'b000000, 48'h0,             48'h0000_1234_5678, 20'h00010, 3'b000, 3'b000, 3'b000, 3'b000, 48'h0000_1234_5678};
    vecs[1] = '{1'b1, 32'h0000_0008, 6'b000011, 48'hAAAA_BBBB_CCCC, 48'hBAD0_BAD0_BAD0, 20'h00002, 3'b110, 3'b001, 3'b110, 3'b110, 48'h0000_1234_5678};
    vecs[2] = '{1'b1, 32'h0000_0004, 6'b100000, 48'h1111_2222_3333, 48'hBAD0_BAD0_BAD0, 20'h00001, 3'b011, 3'b100, 3'b011, 3'b111, 48'h0000_1234_5678};
    vecs[3] = '{1'b0, 32'hFFFF_FFFC, 6'b000000, 48'h0,             48'hDEAD_BEEF_CAFE, 20'hFFFFF, 3'b000, 3'b000, 3'b000, 3'b000, 48'hDEAD_BEEF_CAFE};
    vecs[4] = '{1'b1, 32'h0000_0010, 6'b010100, 48'h0123_4567_89AB, 48'hBAD0_BAD0_BAD0, 20'h00004, 3'b001, 3'b110, 3'b111, 3'b001, 48'hDEAD_BEEF_CAFE};
    vecs[5] = '{1'b1, 32'h0000_0000, 6'b111111, 48'hFFFF_0000_FFFF, 48'hBAD0_BAD0_BAD0, 20'h00000, 3'b000, 3'b111, 3'b000, 3'b000, 48'hDEAD_BEEF_CAFE};
    vecs[6] = '{1'b0, 32'h003F_FFF8, 6'b000000, 48'h0,             48'h5A5A_A5A5_0F0F, 20'hFFFFE, 3'b000, 3'b000, 3'b000, 3'b000, 48'h5A5A_A5A5_0F0F};

    model_en       = 1'b0;
    dq_drv         = 48'h0;
    wb_bus.wb_stb  = 1'b0;
    wb_bus.wb_addr = 32'h0;
    wb_bus.wb_we   = 6'h0;
    wb_bus.wb_din  = 48'h0;
    rst            = 1'b1;

    // Reset values, checked before the first clock edge.
    #3;
    chk("rst_strobes", 64'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 64'h7fff);
    chk("rst_dq_oe", 64'(sram_dq_oe), 64'd0);
    chk("rst_addr", 64'(sram_addr), 64'd0);
    chk("rst_dq_out", 64'(sram_dq_out), 64'd0);
    chk("rst_dout", 64'(wb_bus.wb_dout), 64'd0);
    chk("rst_nak", 64'(wb_bus.wb_nak), 64'd0);
    $display("[TB] reset state checked");
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // 16-word burst with wb_stb held high and the address advanced right
    // after each accept, i.e. while the previous read is still running.
    model_en       = 1'b1;
    wb_bus.wb_we   = 6'h0;
    wb_bus.wb_addr = 32'h0;
    wb_bus.wb_stb  = 1'b1;
    k_acc = 0; k_done = 0; cyc = 0; last_acc = 0; per_err = 0;
    prev_nak = wb_bus.wb_nak;
    while (k_done < 16 && cyc < 200) begin
      tick();
      cyc++;
      if (wb_bus.wb_nak && !prev_nak) begin
        if (k_acc > 0 && (cyc - last_acc) != RD + 1) per_err++;
        last_acc = cyc;
        k_acc++;
        if (k_acc < 16) wb_bus.wb_addr = 32'(4 * k_acc);
        else wb_bus.wb_stb = 1'b0;
      end
      if (!wb_bus.wb_nak && prev_nak) begin
        got[k_done] = wb_bus.wb_dout;
        $display("[TB] burst word %0d dout=0x%012h", k_done, wb_bus.wb_dout);
        k_done++;
      end
      prev_nak = wb_bus.wb_nak;
    end
    wb_bus.wb_stb = 1'b0;
    chk("burst_words_done", 64'(k_done), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < k_done) chk($sformatf("burst_word%0d", i), 64'(got[i]), 64'(i * 12));
    end
    chk("burst_period_errs", 64'(per_err), 64'd0);
    chk("dq_oe_oe_n_overlap", 64'(overlap_errs), 64'd0);
    model_en = 1'b0;
    tick();

    // Reset asserted in the middle of the we_n pulse.
    wb_bus.wb_stb  = 1'b1;
    wb_bus.wb_addr = 32'h0000_0020;
    wb_bus.wb_we   = 6'b111111;
    wb_bus.wb_din  = 48'h1357_9BDF_2468;
    tick();
    tick();
    chk("rstw_pulse_we_n", 64'(sram_we_n), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rstw_we_n", 64'(sram_we_n), 64'h7);
    chk("rstw_dq_oe", 64'(sram_dq_oe), 64'd0);
    chk("rstw_nak", 64'(wb_bus.wb_nak), 64'd0);
    chk("rstw_ce_n", 64'(sram_ce_n), 64'h7);
    tick();
    tick();
    chk("rstw_no_accept_nak", 64'(wb_bus.wb_nak), 64'd0);
    chk("rstw_held_we_n", 64'(sram_we_n), 64'h7);
    wb_bus.wb_stb = 1'b0;
    rst = 1'b0;
    we_after = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sram_we_n != 3'b111 || wb_bus.wb_nak) we_after++;
    end
    chk("rstw_no_later_pulse", 64'(we_after), 64'd0);
    $display("[TB] reset during write pulse checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
